// File: rtl/cam_lru.sv
// Content-addressable table with per-entry payload, insert/lookup/invalidate/clear.
// Define CAM_LRU_REPLACE_EN for age-based LRU victims; otherwise victims follow a round-robin pointer.
module cam_lru #(
   parameter int unsigned LENGTH     = 16,
   parameter int unsigned WIDTH_KEY  = 32,
   parameter int unsigned WIDTH_DATA = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       I_Ins,
   input  logic [WIDTH_KEY-1:0]       I_Ins_Key,
   input  logic [WIDTH_DATA-1:0]      I_Ins_Data,
   output logic [$clog2(LENGTH)-1:0]  O_Ins_Idx,
   output logic                       O_Ins_Evict,
   input  logic                       I_Seek,
   input  logic [WIDTH_KEY-1:0]       I_CKey,
   output logic                       O_Rsp,
   output logic                       O_Hit,
   output logic [$clog2(LENGTH)-1:0]  O_Idx,
   output logic [WIDTH_DATA-1:0]      O_Data,
   input  logic                       I_Inv,
   input  logic [$clog2(LENGTH)-1:0]  I_Inv_Idx,
   input  logic                       I_Clr,
   output logic [LENGTH-1:0]          O_Valid,
   output logic                       O_Full,
   output logic [$clog2(LENGTH):0]    O_Count
);

   localparam int unsigned AW = $clog2(LENGTH);

   logic [LENGTH-1:0]     valid_q, valid_d;
   logic [WIDTH_KEY-1:0]  key_q  [LENGTH];
   logic [WIDTH_DATA-1:0] data_q [LENGTH];

   logic                  rsp_q, hit_q, ins_evict_q;
   logic [AW-1:0]         idx_q, ins_idx_q;
   logic [WIDTH_DATA-1:0] rdata_q;

   logic          seek_hit, ins_hit, free_any, ins_evict, inv_en, ins_we;
   logic [AW-1:0] seek_idx, ins_hit_idx, free_idx, victim, ins_tgt;
   logic [AW:0]   cnt;

   // Priority encoders: the first match in ascending order is kept, so the lowest index wins.
   always_comb begin
      seek_hit    = 1'b0;
      seek_idx    = '0;
      ins_hit     = 1'b0;
      ins_hit_idx = '0;
      free_any    = 1'b0;
      free_idx    = '0;
      for (int unsigned i = 0; i < LENGTH; i++) begin
         if (!seek_hit && valid_q[i] && key_q[i] == I_CKey) begin
            seek_hit = 1'b1;
            seek_idx = AW'(i);
         end
         if (!ins_hit && valid_q[i] && key_q[i] == I_Ins_Key) begin
            ins_hit     = 1'b1;
            ins_hit_idx = AW'(i);
         end
         if (!free_any && !valid_q[i]) begin
            free_any = 1'b1;
            free_idx = AW'(i);
         end
      end
   end

   always_comb begin
      ins_evict = !ins_hit && !free_any;
      if (ins_hit)       ins_tgt = ins_hit_idx;
      else if (free_any) ins_tgt = free_idx;
      else               ins_tgt = victim;
      ins_we = I_Ins && !I_Clr;
      inv_en = I_Inv && !I_Clr && valid_q[I_Inv_Idx] && !(I_Ins && I_Inv_Idx == ins_tgt);
   end

   always_comb begin
      valid_d = valid_q;
      if (I_Clr) begin
         valid_d = '0;
      end else begin
         if (I_Ins) valid_d[ins_tgt] = 1'b1;
         if (inv_en) valid_d[I_Inv_Idx] = 1'b0;
      end
   end

`ifdef CAM_LRU_REPLACE_EN
   logic [AW-1:0] age_q [LENGTH];
   logic [AW-1:0] age_d [LENGTH];
   logic          touch_en;
   logic [AW-1:0] touch_idx, touch_old, inv_age;

   always_comb begin
      victim = '0;
      for (int unsigned i = 0; i < LENGTH; i++)
         if (valid_q[i] && age_q[i] == AW'(LENGTH - 1)) victim = AW'(i);
   end

   // Touch first, then invalidate on the touched ages; both are moves within a recency order so they commute.
   always_comb begin
      age_d     = age_q;
      touch_en  = I_Ins || (I_Seek && seek_hit);
      touch_idx = I_Ins ? ins_tgt : seek_idx;
      if (I_Ins) touch_old = ins_hit ? age_q[ins_hit_idx] : AW'(LENGTH - 1);
      else       touch_old = age_q[seek_idx];
      inv_age   = '0;
      if (I_Clr) begin
         age_d = '{default: '0};
      end else begin
         if (touch_en) begin
            for (int unsigned j = 0; j < LENGTH; j++)
               if (valid_q[j] && AW'(j) != touch_idx && age_q[j] < touch_old)
                  age_d[j] = age_q[j] + AW'(1);
            age_d[touch_idx] = '0;
         end
         if (inv_en) begin
            inv_age = age_d[I_Inv_Idx];
            for (int unsigned j = 0; j < LENGTH; j++)
               if (valid_d[j] && age_d[j] > inv_age) age_d[j] = age_d[j] - AW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) age_q <= '{default: '0};
      else       age_q <= age_d;
   end
`else
   logic [AW-1:0] rr_q, rr_d;

   always_comb begin
      victim = rr_q;
      rr_d   = rr_q;
      if (ins_we && ins_evict) rr_d = rr_q + AW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q     <= '0;
         key_q       <= '{default: '0};
         data_q      <= '{default: '0};
         rsp_q       <= 1'b0;
         hit_q       <= 1'b0;
         idx_q       <= '0;
         rdata_q     <= '0;
         ins_idx_q   <= '0;
         ins_evict_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rsp_q   <= I_Seek;
         hit_q   <= I_Seek && seek_hit;
         idx_q   <= (I_Seek && seek_hit) ? seek_idx : '0;
         rdata_q <= (I_Seek && seek_hit) ? data_q[seek_idx] : '0;
         if (ins_we) begin
            key_q[ins_tgt]  <= I_Ins_Key;
            data_q[ins_tgt] <= I_Ins_Data;
            ins_idx_q       <= ins_tgt;
            ins_evict_q     <= ins_evict;
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < LENGTH; i++) cnt = cnt + (AW+1)'(valid_q[i]);
   end

   assign O_Rsp       = rsp_q;
   assign O_Hit       = hit_q;
   assign O_Idx       = idx_q;
   assign O_Data      = rdata_q;
   assign O_Ins_Idx   = ins_idx_q;
   assign O_Ins_Evict = ins_evict_q;
   assign O_Valid     = valid_q;
   assign O_Full      = &valid_q;
   assign O_Count     = cnt;

endmodule
